// File: rtl/retire_ctrl_pkg.sv
// Shared core definitions for the retire stage: ROB exit packet layout, widths and
// the retire FSM state encoding.
package retire_ctrl_pkg;

  localparam int unsigned N               = 3;
  localparam int unsigned PREG_BITS       = 6;
  localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);

  typedef struct packed {
    logic                 complete;
    logic                 has_dest;
    logic [4:0]           arch_dest;
    logic [PREG_BITS-1:0] phys_dest;
    logic [PREG_BITS-1:0] prev_phys;
    logic                 mispredict;
    logic [31:0]          target_pc;
    logic                 halt;
  } rob_exit_packet_t;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StHalt
  } retire_state_e;

endpackage

// File: rtl/retire_ctrl_if.sv
// ROB-head / commit bus between the ROB, map tables, free list and the retire controller.
interface retire_ctrl_if
  import retire_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = 32
);

  rob_exit_packet_t [N-1:0]                rob_outputs;
  logic [NUM_SCALAR_BITS-1:0]              outputs_valid;
  logic [NUM_SCALAR_BITS-1:0]              num_retiring;
  logic [N-1:0]                            arch_upd_valid;
  logic [N-1:0][4:0]                       arch_upd_reg;
  logic [N-1:0][PREG_BITS-1:0]             arch_upd_preg;
  logic [N-1:0]                            free_valid;
  logic [N-1:0][PREG_BITS-1:0]             free_preg;
  logic                                    flush;
  logic [31:0]                             redirect_pc;
  logic                                    halted;
  logic [CNT_BITS-1:0]                     retired_total;

  // The retire controller.
  modport master (
    input  rob_outputs, outputs_valid,
    output num_retiring, arch_upd_valid, arch_upd_reg, arch_upd_preg,
    output free_valid, free_preg, flush, redirect_pc, halted, retired_total
  );

  // The ROB and the rest of the core.
  modport slave (
    output rob_outputs, outputs_valid,
    input  num_retiring, arch_upd_valid, arch_upd_reg, arch_upd_preg,
    input  free_valid, free_preg, flush, redirect_pc, halted, retired_total
  );

endinterface

// File: rtl/retire_ctrl_prefix.sv
// Oldest-first scan of the ROB head: how many entries may commit this cycle, and
// whether the youngest of them ends the group with a halt or a mispredict.
module retire_ctrl_prefix
  import retire_ctrl_pkg::*;
(
  input  rob_exit_packet_t [N-1:0]   rob_outputs_i,
  input  logic [NUM_SCALAR_BITS-1:0] outputs_valid_i,
  output logic [NUM_SCALAR_BITS-1:0] k_o,
  output logic [N-1:0]               mask_o,
  output logic                       halt_o,
  output logic                       mispredict_o,
  output logic [31:0]                target_pc_o
);

  logic blocked;

  always_comb begin
    k_o          = '0;
    mask_o       = '0;
    halt_o       = 1'b0;
    mispredict_o = 1'b0;
    target_pc_o  = '0;
    blocked      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!blocked && (i < int'(outputs_valid_i)) && rob_outputs_i[i].complete) begin
        mask_o[i] = 1'b1;
        k_o       = NUM_SCALAR_BITS'(i + 1);
        // A flagged entry commits but closes the group; halt wins over mispredict.
        if (rob_outputs_i[i].halt) begin
          halt_o  = 1'b1;
          blocked = 1'b1;
        end else if (rob_outputs_i[i].mispredict) begin
          mispredict_o = 1'b1;
          target_pc_o  = rob_outputs_i[i].target_pc;
          blocked      = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_ctrl.sv
// In-order commit scheduler on the ROB head: picks the retire count, drives map-table
// and free-list updates, and sequences mispredict flush and halt.
module retire_ctrl
  import retire_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = 32
) (
  input  logic          clock,
  input  logic          reset,
  retire_ctrl_if.master bus
);

  retire_state_e              state_q;
  logic                       flush_q;
  logic [31:0]                redirect_pc_q;
  logic                       halted_q;
  logic [CNT_BITS-1:0]        retired_total_q;
  logic [CNT_BITS-1:0]        retired_total_d;

  logic [NUM_SCALAR_BITS-1:0] k;
  logic [N-1:0]               mask;
  logic                       halt_hit;
  logic                       mispredict_hit;
  logic [31:0]                target_pc;
  logic                       retire_en;
  logic [NUM_SCALAR_BITS-1:0] num_retiring;

  retire_ctrl_prefix u_prefix (
    .rob_outputs_i   (bus.rob_outputs),
    .outputs_valid_i (bus.outputs_valid),
    .k_o             (k),
    .mask_o          (mask),
    .halt_o          (halt_hit),
    .mispredict_o    (mispredict_hit),
    .target_pc_o     (target_pc)
  );

  assign retire_en       = (state_q == StRun) && !reset;
  assign num_retiring    = retire_en ? k : '0;
  assign retired_total_d = retired_total_q + CNT_BITS'(num_retiring);

  always_comb begin
    bus.arch_upd_valid = '0;
    bus.arch_upd_reg   = '0;
    bus.arch_upd_preg  = '0;
    bus.free_valid     = '0;
    bus.free_preg      = '0;
    for (int i = 0; i < N; i++) begin
      if (retire_en && mask[i]) begin
        bus.arch_upd_valid[i] = bus.rob_outputs[i].has_dest;
        bus.free_valid[i]     = bus.rob_outputs[i].has_dest;
        bus.arch_upd_reg[i]   = bus.rob_outputs[i].arch_dest;
        bus.arch_upd_preg[i]  = bus.rob_outputs[i].phys_dest;
        bus.free_preg[i]      = bus.rob_outputs[i].prev_phys;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StRun;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      halted_q        <= 1'b0;
      retired_total_q <= '0;
    end else begin
      retired_total_q <= retired_total_d;
      unique case (state_q)
        StRun: begin
          flush_q <= 1'b0;
          if (halt_hit) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (mispredict_hit) begin
            state_q       <= StFlush;
            flush_q       <= 1'b1;
            redirect_pc_q <= target_pc;
          end
        end
        StFlush: begin
          flush_q <= 1'b0;
          state_q <= StRun;
        end
        StHalt: begin
          flush_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= StRun;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.num_retiring  = num_retiring;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.halted        = halted_q;
  assign bus.retired_total = retired_total_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl: commit counts, slot outputs, flush, halt and reset.
module tb_retire_ctrl;
  import retire_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] exp_total;

  retire_ctrl_if #(.CNT_BITS(32)) bus ();

  retire_ctrl #(.CNT_BITS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic rob_exit_packet_t pkt(input logic c, input logic hd, input logic [4:0] ad,
                                           input logic [5:0] pd, input logic [5:0] pp,
                                           input logic mp, input logic [31:0] pc,
                                           input logic h);
    rob_exit_packet_t p;
    p.complete   = c;
    p.has_dest   = hd;
    p.arch_dest  = ad;
    p.phys_dest  = pd;
    p.prev_phys  = pp;
    p.mispredict = mp;
    p.target_pc  = pc;
    p.halt       = h;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Three complete plain entries; slot 1 has no destination.
  task automatic set_plain();
    bus.rob_outputs[0] = pkt(1'b1, 1'b1, 5'd1, 6'd10, 6'd20, 1'b0, 32'h0, 1'b0);
    bus.rob_outputs[1] = pkt(1'b1, 1'b0, 5'd2, 6'd11, 6'd21, 1'b0, 32'h0, 1'b0);
    bus.rob_outputs[2] = pkt(1'b1, 1'b1, 5'd3, 6'd12, 6'd22, 1'b0, 32'h0, 1'b0);
    bus.outputs_valid  = 2'd3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_plain();
    #1;
    checks++;
    if (bus.num_retiring !== 2'd0) begin
      errors++; $display("FAIL reset_num_retiring: got %0d want 0", bus.num_retiring);
    end
    checks++;
    if (bus.arch_upd_valid !== 3'b000 || bus.free_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got arch=%b free=%b want 000/000",
                         bus.arch_upd_valid, bus.free_valid);
    end
    tick();
    tick();
    bus.outputs_valid = 2'd0;
    reset = 1'b0;
    checks++;
    if (bus.flush !== 1'b0 || bus.halted !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got flush=%b halted=%b pc=%h want 0/0/0",
                         bus.flush, bus.halted, bus.redirect_pc);
    end
    checks++;
    if (bus.retired_total !== 32'd0) begin
      errors++; $display("FAIL reset_total: got %0d want 0", bus.retired_total);
    end
    exp_total = 0;
  endtask

  task automatic test_all_complete();
    set_plain();
    #1;
    checks++;
    if (bus.num_retiring !== 2'd3) begin
      errors++; $display("FAIL all_num_retiring: got %0d want 3", bus.num_retiring);
    end
    checks++;
    if (bus.arch_upd_valid !== 3'b101 || bus.free_valid !== 3'b101) begin
      errors++; $display("FAIL all_valids: got arch=%b free=%b want 101/101",
                         bus.arch_upd_valid, bus.free_valid);
    end
    checks++;
    if (bus.arch_upd_reg[2] !== 5'd3 || bus.arch_upd_preg[0] !== 6'd10 ||
        bus.free_preg[2] !== 6'd22) begin
      errors++; $display("FAIL all_data: got reg2=%0d preg0=%0d free2=%0d want 3/10/22",
                         bus.arch_upd_reg[2], bus.arch_upd_preg[0], bus.free_preg[2]);
    end
    tick();
    bus.outputs_valid = 2'd0;
    exp_total = exp_total + 3;
    checks++;
    if (bus.retired_total !== exp_total) begin
      errors++; $display("FAIL all_total: got %0d want %0d", bus.retired_total, exp_total);
    end
  endtask

  task automatic test_incomplete_gap();
    set_plain();
    bus.rob_outputs[1].complete = 1'b0;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd1) begin
      errors++; $display("FAIL gap_num_retiring: got %0d want 1", bus.num_retiring);
    end
    checks++;
    if (bus.arch_upd_valid !== 3'b001 || bus.free_valid !== 3'b001) begin
      errors++; $display("FAIL gap_valids: got arch=%b free=%b want 001/001",
                         bus.arch_upd_valid, bus.free_valid);
    end
    tick();
    exp_total = exp_total + 1;
    // Oldest entry incomplete blocks everything behind it.
    set_plain();
    bus.rob_outputs[0].complete = 1'b0;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd0 || bus.arch_upd_valid !== 3'b000) begin
      errors++; $display("FAIL head_incomplete: got k=%0d arch=%b want 0/000",
                         bus.num_retiring, bus.arch_upd_valid);
    end
    tick();
    bus.outputs_valid = 2'd0;
    checks++;
    if (bus.retired_total !== exp_total) begin
      errors++; $display("FAIL gap_total: got %0d want %0d", bus.retired_total, exp_total);
    end
  endtask

  task automatic test_mispredict_flush();
    set_plain();
    bus.rob_outputs[1].mispredict = 1'b1;
    bus.rob_outputs[1].target_pc  = 32'h400;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd2 || bus.arch_upd_valid !== 3'b001) begin
      errors++; $display("FAIL misp_num_retiring: got k=%0d arch=%b want 2/001",
                         bus.num_retiring, bus.arch_upd_valid);
    end
    tick();
    exp_total = exp_total + 2;
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h400) begin
      errors++; $display("FAIL misp_flush: got flush=%b pc=%h want 1/00000400",
                         bus.flush, bus.redirect_pc);
    end
    checks++;
    if (bus.num_retiring !== 2'd0 || bus.free_valid !== 3'b000) begin
      errors++; $display("FAIL misp_flush_hold: got k=%0d free=%b want 0/000",
                         bus.num_retiring, bus.free_valid);
    end
    tick();
    checks++;
    if (bus.flush !== 1'b0 || bus.redirect_pc !== 32'h400) begin
      errors++; $display("FAIL misp_after: got flush=%b pc=%h want 0/00000400",
                         bus.flush, bus.redirect_pc);
    end
    checks++;
    if (bus.retired_total !== exp_total) begin
      errors++; $display("FAIL misp_total: got %0d want %0d", bus.retired_total, exp_total);
    end
    set_plain();
    #1;
    checks++;
    if (bus.num_retiring !== 2'd3) begin
      errors++; $display("FAIL misp_resume: got %0d want 3", bus.num_retiring);
    end
    tick();
    bus.outputs_valid = 2'd0;
    exp_total = exp_total + 3;
  endtask

  task automatic test_halt();
    set_plain();
    bus.rob_outputs[0].halt       = 1'b1;
    bus.rob_outputs[0].mispredict = 1'b1;
    bus.rob_outputs[0].target_pc  = 32'h800;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd1 || bus.arch_upd_valid !== 3'b001) begin
      errors++; $display("FAIL halt_num_retiring: got k=%0d arch=%b want 1/001",
                         bus.num_retiring, bus.arch_upd_valid);
    end
    tick();
    exp_total = exp_total + 1;
    checks++;
    if (bus.halted !== 1'b1 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL halt_state: got halted=%b flush=%b want 1/0",
                         bus.halted, bus.flush);
    end
    set_plain();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.num_retiring !== 2'd0 || bus.arch_upd_valid !== 3'b000 ||
          bus.halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold[%0d]: got k=%0d arch=%b halted=%b want 0/000/1",
                           i, bus.num_retiring, bus.arch_upd_valid, bus.halted);
      end
      tick();
    end
    checks++;
    if (bus.retired_total !== exp_total) begin
      errors++; $display("FAIL halt_total: got %0d want %0d", bus.retired_total, exp_total);
    end
  endtask

  task automatic test_reset_in_flush();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.retired_total !== 32'd0) begin
      errors++; $display("FAIL halt_reset: got halted=%b total=%0d want 0/0",
                         bus.halted, bus.retired_total);
    end
    set_plain();
    bus.rob_outputs[0].mispredict = 1'b1;
    bus.rob_outputs[0].target_pc  = 32'h123;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd1) begin
      errors++; $display("FAIL slot0_misp_block: got %0d want 1", bus.num_retiring);
    end
    tick();
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h123) begin
      errors++; $display("FAIL rf_flush: got flush=%b pc=%h want 1/00000123",
                         bus.flush, bus.redirect_pc);
    end
    reset = 1'b1;
    set_plain();
    #1;
    checks++;
    if (bus.num_retiring !== 2'd0 || bus.free_valid !== 3'b000) begin
      errors++; $display("FAIL rf_reset_comb: got k=%0d free=%b want 0/000",
                         bus.num_retiring, bus.free_valid);
    end
    tick();
    reset = 1'b0;
    exp_total = 0;
    checks++;
    if (bus.flush !== 1'b0 || bus.halted !== 1'b0 || bus.retired_total !== 32'd0 ||
        bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rf_cleared: got flush=%b halted=%b total=%0d pc=%h want 0/0/0/0",
                         bus.flush, bus.halted, bus.retired_total, bus.redirect_pc);
    end
    #1;
    checks++;
    if (bus.num_retiring !== 2'd3) begin
      errors++; $display("FAIL rf_run: got %0d want 3", bus.num_retiring);
    end
    tick();
    bus.outputs_valid = 2'd0;
    exp_total = exp_total + 3;
  endtask

  task automatic test_partial_valid();
    set_plain();
    bus.outputs_valid = 2'd2;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd2) begin
      errors++; $display("FAIL partial_num_retiring: got %0d want 2", bus.num_retiring);
    end
    checks++;
    if (bus.arch_upd_valid[2] !== 1'b0 || bus.free_valid[2] !== 1'b0) begin
      errors++; $display("FAIL partial_slot2: got arch=%b free=%b want 0/0",
                         bus.arch_upd_valid[2], bus.free_valid[2]);
    end
    tick();
    exp_total = exp_total + 2;
    bus.outputs_valid = 2'd0;
    #1;
    checks++;
    if (bus.num_retiring !== 2'd0) begin
      errors++; $display("FAIL zero_valid: got %0d want 0", bus.num_retiring);
    end
    tick();
    checks++;
    if (bus.retired_total !== exp_total) begin
      errors++; $display("FAIL partial_total: got %0d want %0d", bus.retired_total, exp_total);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_total = 0;
    reset     = 1'b1;
    bus.rob_outputs   = '0;
    bus.outputs_valid = '0;
    tick();
    test_reset();
    test_all_complete();
    test_incomplete_gap();
    test_mispredict_flush();
    test_halt();
    test_reset_in_flush();
    test_partial_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_ctrl.md
Name: retire_ctrl

Overview:
- In-order commit scheduler sitting on the ROB head in the N-wide R10K-style core.
- Each cycle it inspects up to N head ROB exit packets and decides how many retire, setting `num_retiring` into the ROB.
- Drives architectural map-table updates and free-list returns.
- Sequences branch-mispredict recovery (pipeline flush and PC redirect) and processor halt.

Parameters:
- N, 3, superscalar width; number of ROB head entries examined per cycle.
- CNT_BITS, 32, width of the retired-instruction counter.
- NUM_SCALAR_BITS, $clog2(N+1), width of count ports.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- rob_outputs  in  N x $bits(ROB_EXIT_PACKET)  head entries, index 0 oldest; fields: complete, has_dest, arch_dest[4:0], phys_dest[PREG_BITS-1:0], prev_phys[PREG_BITS-1:0], mispredict, target_pc[31:0], halt
- outputs_valid  in  NUM_SCALAR_BITS  number of valid head entries (0..N)
- num_retiring  out  NUM_SCALAR_BITS  entries the ROB pops this cycle
- arch_upd_valid  out  N  per-slot architectural map write enable
- arch_upd_reg  out  N x 5  architectural register per slot
- arch_upd_preg  out  N x PREG_BITS  new committed physical register per slot
- free_valid  out  N  per-slot free-list return enable
- free_preg  out  N x PREG_BITS  physical register freed (prev_phys)
- flush  out  1  registered one-cycle pipeline flush
- redirect_pc  out  32  fetch target, valid while flush=1
- halted  out  1  sticky halt indication
- retired_total  out  CNT_BITS  running count of retired instructions

Behaviour:
- FSM states: RUN, FLUSH, HALT. Reset value is RUN.
- Reset values: flush=0, redirect_pc=0, halted=0, retired_total=0.
- While reset=1, all combinational outputs are 0: num_retiring, arch_upd_valid, free_valid.
- RUN, candidate retire count k (combinational):
  - Scan i=0..outputs_valid-1.
  - Stop before the first entry with complete=0.
  - An entry with mispredict=1 or halt=1 and complete=1 retires, but no younger entry in the group retires.
  - num_retiring = k, combinational, same cycle; ROB pops on the next edge.
- Slot i<k:
  - free_valid[i] = arch_upd_valid[i] = has_dest.
  - arch_upd_reg[i] = arch_dest, arch_upd_preg[i] = phys_dest, free_preg[i] = prev_phys.
  - Slots i>=k have both valids=0. Data outputs for those slots are don't-care; drive them 0.
- Invariant: num_retiring <= outputs_valid <= N.
- Counter: retired_total += num_retiring each clock; wraps modulo 2^CNT_BITS.
- Transitions:
  - RUN -> FLUSH when the last retired entry had mispredict=1 and halt=0. Next cycle: flush=1, redirect_pc = that entry's target_pc.
  - RUN -> HALT when any retired entry had halt=1. Halt has priority over mispredict in the same entry. Next cycle: halted=1, flush=0.
  - FLUSH lasts exactly one cycle with num_retiring=0, then returns to RUN. flush drops to 0; redirect_pc holds its value.
  - HALT is terminal until reset: num_retiring=0, all valids 0, halted=1.
- Boundary cases:
  - outputs_valid=0 gives k=0.
  - Entry 0 incomplete gives k=0 even if younger entries are complete.
  - A mispredict in slot 0 blocks slots 1..N-1 in the same cycle.
  - Reset asserted in FLUSH or HALT returns to RUN next edge with all registered outputs cleared.
  - ROB wrap-around is invisible here; slot ordering is always oldest-first.

Decomposition:
- ROB_EXIT_PACKET fields, PREG_BITS and `N` belong in the shared sys_defs package. The retire FSM state enum is added there too.
- One sub-module, retire_prefix: purely combinational oldest-first scan producing k and the per-slot retire mask.
- retire_ctrl holds the FSM, the flush/redirect registers and the counter.

Test Plan:
- All 3 entries complete, outputs_valid=3, no flags -> num_retiring=3; free_valid and arch_upd_valid follow has_dest; retired_total +3 next cycle.
- Entries {complete=1,0,1}, outputs_valid=3 -> num_retiring=1; only slot 0 valids asserted.
- Slot 1 complete with mispredict=1, target_pc=0x400 -> num_retiring=2; next cycle flush=1, redirect_pc=0x400, num_retiring=0; following cycle flush=0 and retire resumes.
- Slot 0 carries halt=1 and mispredict=1, 3 valid complete entries -> num_retiring=1; next cycle halted=1, flush=0; num_retiring stays 0 for 10 further cycles despite complete inputs.
- Reset asserted during the FLUSH cycle -> next cycle flush=0, halted=0, retired_total=0, state RUN; num_retiring=0 while reset=1.
- outputs_valid=2 with slot 2 also showing complete=1 -> num_retiring=2; no valid asserted on slot 2.
